multi_port_mem_arbiter: RTL and testbench

Parametrised N-port successor to the two-port instruction/data memory arbiter. It sits between the CPU's bus masters (instruction prefetch, data/EU, DMA, debug) and the single external memory port. It grants one memory transaction at a time under fixed-priority or round-robin policy and routes the ack and read data back to the granted master. Requests flagged as I/O never reach memory and are never granted.

---
 rtl/mem_arb_pkg.sv | 28 ++
 rtl/rr_priority_select.sv | 49 ++++
 rtl/multi_port_mem_arbiter.sv | 146 ++++++++++++++
 tb/tb_multi_port_mem_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
//   Shared definitions for the multi-port memory arbiter: supported port-count
//   bounds, the widest port index type, the index-width helper, the idle
//   byte-select pattern and the grant FSM state encoding.
//   No ports (package).
package mem_arb_pkg;

   localparam int MIN_PORTS = 2;
   localparam int MAX_PORTS = 8;
   localparam int MAX_IDX_W = 3;

   // Wide enough to index any supported port count.
   typedef logic [MAX_IDX_W-1:0] port_idx_t;

   // Idle memory-side byte selects are all ones; sliced to DATA_WIDTH/8 at use.
   localparam logic [15:0] IDLE_BYTESEL = '1;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } arb_state_t;

   // Index width for n ports, never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_priority_select.sv
// rr_priority_select
//   Combinational winner selection over the eligible request vector.
//   Round-robin mode searches upward from rr_ptr with wrap-around; fixed mode
//   always starts the search at index 0 (lowest index wins).
//   Ports:
//     eligible      in   NUM_PORTS  requests that may be granted
//     rr_ptr        in   IDX_W      highest-priority index (round-robin only)
//     any_eligible  out  1          at least one eligible request
//     win_idx       out  IDX_W      winning index (0 when none)
//     win_onehot    out  NUM_PORTS  one-hot winner (0 when none)
module rr_priority_select
   import mem_arb_pkg::*;
#(
   parameter int NUM_PORTS   = 2,
   parameter int ROUND_ROBIN = 0,
   parameter int IDX_W       = idx_width(NUM_PORTS)
) (
   input  logic [NUM_PORTS-1:0] eligible,
   input  logic [IDX_W-1:0]     rr_ptr,
   output logic                 any_eligible,
   output logic [IDX_W-1:0]     win_idx,
   output logic [NUM_PORTS-1:0] win_onehot
);

   int unsigned      base;
   int unsigned      cand;
   logic [IDX_W-1:0] cand_idx;

   always_comb begin
      base         = (ROUND_ROBIN != 0) ? 32'(rr_ptr) : 32'd0;
      cand         = 0;
      cand_idx     = '0;
      any_eligible = 1'b0;
      win_idx      = '0;
      win_onehot   = '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         cand     = (base + 32'(k)) % NUM_PORTS;
         cand_idx = IDX_W'(cand);
         if (!any_eligible && eligible[cand_idx]) begin
            any_eligible = 1'b1;
            win_idx      = cand_idx;
         end
      end
      if (any_eligible) begin
         win_onehot[win_idx] = 1'b1;
      end
   end

endmodule

// File: rtl/multi_port_mem_arbiter.sv
// multi_port_mem_arbiter
//   Grants the single external memory port to one of NUM_PORTS bus masters at
//   a time (fixed priority or round-robin) and routes the memory ack and read
//   data back to the granted master. I/O-flagged requests are never granted.
//   Ports:
//     clk, reset_n                      clock, async active-low reset
//     m_addr/m_data_out/m_access/m_io/m_wr_en/m_bytesel   per-master request
//     m_data_in/m_ack                   per-master response (granted port only)
//     q_m_addr/q_m_data_out/q_m_wr_en/q_m_bytesel/q_m_access  memory request
//     q_m_data_in/q_m_ack               memory response
//     grant_idx                         port driving the memory side
//     busy                              grant held
//
//   state   | meaning
//   --------+----------------------------------------------------------------
//   ST_IDLE | no grant; winner presented combinationally, latched at the edge
//   ST_BUSY | grant held on grant_q until q_m_ack, no re-arbitration
module multi_port_mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int  NUM_PORTS   = 2,
   parameter int  ADDR_WIDTH  = 19,
   parameter int  DATA_WIDTH  = 16,
   parameter int  ROUND_ROBIN = 0,
   localparam int IDX_W       = idx_width(NUM_PORTS),
   localparam int BW          = DATA_WIDTH / 8
) (
   input  logic                                  clk,
   input  logic                                  reset_n,
   input  logic [NUM_PORTS-1:0][ADDR_WIDTH:1]    m_addr,
   input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  m_data_out,
   output logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  m_data_in,
   input  logic [NUM_PORTS-1:0]                  m_access,
   input  logic [NUM_PORTS-1:0]                  m_io,
   input  logic [NUM_PORTS-1:0]                  m_wr_en,
   input  logic [NUM_PORTS-1:0][BW-1:0]          m_bytesel,
   output logic [NUM_PORTS-1:0]                  m_ack,
   output logic [ADDR_WIDTH:1]                   q_m_addr,
   output logic [DATA_WIDTH-1:0]                 q_m_data_out,
   output logic                                  q_m_wr_en,
   output logic [BW-1:0]                         q_m_bytesel,
   output logic                                  q_m_access,
   input  logic [DATA_WIDTH-1:0]                 q_m_data_in,
   input  logic                                  q_m_ack,
   output logic [IDX_W-1:0]                      grant_idx,
   output logic                                  busy
);

   arb_state_t           state, state_nxt;
   logic [IDX_W-1:0]     grant_q, grant_nxt;
   logic [NUM_PORTS-1:0] grant_oh_q, grant_oh_nxt;
   logic [IDX_W-1:0]     rr_ptr, rr_ptr_nxt;

   logic [NUM_PORTS-1:0] eligible;
   logic                 any_eligible;
   logic [IDX_W-1:0]     win_idx;
   logic [NUM_PORTS-1:0] win_onehot;
   logic [IDX_W-1:0]     sel_idx;
   logic                 present;

   assign eligible = m_access & ~m_io;

   rr_priority_select #(
      .NUM_PORTS   (NUM_PORTS),
      .ROUND_ROBIN (ROUND_ROBIN),
      .IDX_W       (IDX_W)
   ) u_select (
      .eligible     (eligible),
      .rr_ptr       (rr_ptr),
      .any_eligible (any_eligible),
      .win_idx      (win_idx),
      .win_onehot   (win_onehot)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= ST_IDLE;
         grant_q    <= '0;
         grant_oh_q <= '0;
         rr_ptr     <= '0;
      end else begin
         state      <= state_nxt;
         grant_q    <= grant_nxt;
         grant_oh_q <= grant_oh_nxt;
         rr_ptr     <= rr_ptr_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      grant_nxt    = grant_q;
      grant_oh_nxt = grant_oh_q;
      rr_ptr_nxt   = rr_ptr;
      case (state)
         ST_IDLE: begin
            if (any_eligible) begin
               state_nxt    = ST_BUSY;
               grant_nxt    = win_idx;
               grant_oh_nxt = win_onehot;
            end
         end
         ST_BUSY: begin
            if (q_m_ack) begin
               state_nxt  = ST_IDLE;
               rr_ptr_nxt = (grant_q == IDX_W'(NUM_PORTS - 1)) ? '0 : grant_q + IDX_W'(1);
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      busy    = (state == ST_BUSY);
      sel_idx = busy ? grant_q : win_idx;
      // Gated by reset_n so held requests cannot reach memory while in reset.
      present = reset_n && (busy || any_eligible);

      grant_idx    = sel_idx;
      q_m_addr     = '0;
      q_m_data_out = '0;
      q_m_wr_en    = 1'b0;
      q_m_bytesel  = IDLE_BYTESEL[BW-1:0];
      q_m_access   = 1'b0;
      m_ack        = '0;
      m_data_in    = '0;

      if (present) begin
         q_m_addr     = m_addr[sel_idx];
         q_m_data_out = m_data_out[sel_idx];
         q_m_wr_en    = m_wr_en[sel_idx];
         q_m_bytesel  = m_bytesel[sel_idx];
         // Drop the request in the ack cycle so memory never sees a second access.
         q_m_access   = busy ? (m_access[sel_idx] && !q_m_ack) : 1'b1;
      end

      if (busy) begin
         for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant_oh_q[i]) begin
               m_data_in[i] = q_m_data_in;
               m_ack[i]     = q_m_ack;
            end
         end
      end
   end

endmodule

// File: tb/tb_multi_port_mem_arbiter.sv
module tb_multi_port_mem_arbiter;

   localparam int NP = 4;
   localparam int AW = 19;
   localparam int DW = 16;
   localparam int BW = 2;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   // Instance A: fixed priority
   logic [NP-1:0][AW:1]   a_addr;
   logic [NP-1:0][DW-1:0] a_dout, a_din;
   logic [NP-1:0]         a_access, a_io, a_wr, a_ack;
   logic [NP-1:0][BW-1:0] a_bsel;
   logic [AW:1]           a_qaddr;
   logic [DW-1:0]         a_qdout, a_qdin;
   logic                  a_qwr, a_qacc, a_qack, a_busy;
   logic [BW-1:0]         a_qbsel;
   logic [1:0]            a_gidx;

   // Instance B: round-robin
   logic [NP-1:0][AW:1]   b_addr;
   logic [NP-1:0][DW-1:0] b_dout, b_din;
   logic [NP-1:0]         b_access, b_io, b_wr, b_ack;
   logic [NP-1:0][BW-1:0] b_bsel;
   logic [AW:1]           b_qaddr;
   logic [DW-1:0]         b_qdout, b_qdin;
   logic                  b_qwr, b_qacc, b_qack, b_busy;
   logic [BW-1:0]         b_qbsel;
   logic [1:0]            b_gidx;

   multi_port_mem_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROUND_ROBIN(0)) dut_fp (
      .clk(clk), .reset_n(reset_n),
      .m_addr(a_addr), .m_data_out(a_dout), .m_data_in(a_din), .m_access(a_access),
      .m_io(a_io), .m_wr_en(a_wr), .m_bytesel(a_bsel), .m_ack(a_ack),
      .q_m_addr(a_qaddr), .q_m_data_out(a_qdout), .q_m_wr_en(a_qwr), .q_m_bytesel(a_qbsel),
      .q_m_access(a_qacc), .q_m_data_in(a_qdin), .q_m_ack(a_qack),
      .grant_idx(a_gidx), .busy(a_busy)
   );

   multi_port_mem_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROUND_ROBIN(1)) dut_rr (
      .clk(clk), .reset_n(reset_n),
      .m_addr(b_addr), .m_data_out(b_dout), .m_data_in(b_din), .m_access(b_access),
      .m_io(b_io), .m_wr_en(b_wr), .m_bytesel(b_bsel), .m_ack(b_ack),
      .q_m_addr(b_qaddr), .q_m_data_out(b_qdout), .q_m_wr_en(b_qwr), .q_m_bytesel(b_qbsel),
      .q_m_access(b_qacc), .q_m_data_in(b_qdin), .q_m_ack(b_qack),
      .grant_idx(b_gidx), .busy(b_busy)
   );

   typedef struct {
      int          port;
      logic [15:0] data;
   } exp_t;

   exp_t exp_a[$];
   exp_t exp_b[$];
   int   vectors     = 0;
   int   miscompares = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard monitor: every ack presented by a DUT is matched against the
   // oldest expected response for that instance.
   task automatic mon(input int inst, input logic [NP-1:0] ack,
                      input logic [NP-1:0][DW-1:0] din, input logic busy);
      exp_t                  e;
      logic [NP-1:0][DW-1:0] rest;
      int                    qsz;
      qsz = (inst == 0) ? exp_a.size() : exp_b.size();
      if (ack == '0) begin
         if (!busy) chk((inst == 0) ? "a_idle_din" : "b_idle_din", 64'(din), 64'd0);
      end else if (qsz == 0) begin
         chk((inst == 0) ? "a_unexpected_ack" : "b_unexpected_ack", 64'(ack), 64'd0);
      end else begin
         if (inst == 0) e = exp_a.pop_front();
         else           e = exp_b.pop_front();
         chk((inst == 0) ? "a_ack_port" : "b_ack_port", 64'(ack), 64'd1 << e.port);
         chk((inst == 0) ? "a_ack_data" : "b_ack_data", 64'(din[e.port]), 64'(e.data));
         rest          = din;
         rest[e.port]  = '0;
         chk((inst == 0) ? "a_ack_other_din" : "b_ack_other_din", 64'(rest), 64'd0);
      end
   endtask

   always @(negedge clk) begin
      mon(0, a_ack, a_din, a_busy);
      mon(1, b_ack, b_din, b_busy);
   end

   // One transaction on instance A; memory acks after lat cycles of request.
   task automatic a_single(input int p, input logic [AW:1] addr, input logic [DW-1:0] wdata,
                           input logic wr, input logic [BW-1:0] bsel, input logic [DW-1:0] rdata,
                           input int lat, output int acc_cnt);
      logic [NP-1:0][DW-1:0] rest;
      a_access[p] = 1'b1;
      a_addr[p]   = addr;
      a_dout[p]   = wdata;
      a_wr[p]     = wr;
      a_bsel[p]   = bsel;
      exp_a.push_back('{p, rdata});
      acc_cnt = 0;
      for (int c = 0; c < lat; c++) begin
         @(negedge clk);
         if (a_qacc) acc_cnt++;
         chk("req_gidx",  64'(a_gidx),  64'(p));
         chk("req_qaddr", 64'(a_qaddr), 64'(addr));
         chk("req_qdout", 64'(a_qdout), 64'(wdata));
         chk("req_qwr",   64'(a_qwr),   64'(wr));
         chk("req_qbsel", 64'(a_qbsel), 64'(bsel));
         chk("req_busy",  64'(a_busy),  (c > 0) ? 64'd1 : 64'd0);
         rest    = a_din;
         rest[p] = '0;
         chk("req_nongrant_din", 64'(rest), 64'd0);
         tick();
      end
      a_qack = 1'b1;
      a_qdin = rdata;
      @(negedge clk);
      if (a_qacc) acc_cnt++;
      chk("ack_cycle_busy", 64'(a_busy), 64'd1);
      tick();
      a_qack      = 1'b0;
      a_qdin      = '0;
      a_access[p] = 1'b0;
      a_wr[p]     = 1'b0;
      a_dout[p]   = '0;
      a_bsel[p]   = '0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      reset_n  = 1'b0;
      a_addr   = '0; a_dout = '0; a_access = '0; a_io = '0; a_wr = '0; a_bsel = '0;
      a_qdin   = '0; a_qack = 1'b0;
      b_addr   = '0; b_dout = '0; b_access = '0; b_io = '0; b_wr = '0; b_bsel = '0;
      b_qdin   = '0; b_qack = 1'b0;

      repeat (2) tick();
      chk("rst_busy_a",  64'(a_busy),  64'd0);
      chk("rst_qacc_a",  64'(a_qacc),  64'd0);
      chk("rst_qbsel_a", 64'(a_qbsel), 64'h3);
      chk("rst_qaddr_a", 64'(a_qaddr), 64'd0);
      chk("rst_ack_a",   64'(a_ack),   64'd0);
      chk("rst_busy_b",  64'(b_busy),  64'd0);
      chk("rst_gidx_b",  64'(b_gidx),  64'd0);
      reset_n = 1'b1;
      tick();

      // Port 1 read, three request cycles before the ack cycle.
      a_single(1, 19'h00100, 16'h0000, 1'b0, 2'b11, 16'h1234, 3, cnt);
      chk("t1_qacc_cycles", 64'(cnt), 64'd3);

      // Memory ack while idle is ignored.
      a_qack = 1'b1;
      a_qdin = 16'hFFFF;
      @(negedge clk);
      chk("idle_ack_busy", 64'(a_busy), 64'd0);
      tick();
      a_qack = 1'b0;
      a_qdin = '0;
      @(negedge clk);
      chk("idle_ack_state", 64'(a_busy), 64'd0);
      tick();

      // Write from port 1.
      a_single(1, 19'h00200, 16'hBEEF, 1'b1, 2'b01, 16'h0000, 2, cnt);
      chk("wr_qacc_cycles", 64'(cnt), 64'd2);

      // Fixed priority: ports 0 and 2 together.
      a_access[0] = 1'b1; a_addr[0] = 19'h00010;
      a_access[2] = 1'b1; a_addr[2] = 19'h00020;
      exp_a.push_back('{0, 16'h0A0A});
      exp_a.push_back('{2, 16'h2B2B});
      @(negedge clk);
      chk("fp_first_gidx",  64'(a_gidx),  64'd0);
      chk("fp_first_qacc",  64'(a_qacc),  64'd1);
      chk("fp_first_qaddr", 64'(a_qaddr), 64'h10);
      tick();
      a_qack = 1'b1; a_qdin = 16'h0A0A;
      @(negedge clk);
      chk("fp_turn_qacc", 64'(a_qacc), 64'd0);
      tick();
      a_qack = 1'b0; a_qdin = '0; a_access[0] = 1'b0;
      @(negedge clk);
      chk("fp_second_gidx",  64'(a_gidx),  64'd2);
      chk("fp_second_qacc",  64'(a_qacc),  64'd1);
      chk("fp_second_busy",  64'(a_busy),  64'd0);
      chk("fp_second_qaddr", 64'(a_qaddr), 64'h20);
      tick();
      a_qack = 1'b1; a_qdin = 16'h2B2B;
      @(negedge clk);
      tick();
      a_qack = 1'b0; a_qdin = '0; a_access[2] = 1'b0;

      // I/O request on port 0 is never granted; port 1 gets memory.
      a_io[0] = 1'b1; a_access[0] = 1'b1; a_addr[0] = 19'h7FFFF;
      @(negedge clk);
      chk("io_only_qacc", 64'(a_qacc), 64'd0);
      tick();
      @(negedge clk);
      chk("io_only_busy", 64'(a_busy), 64'd0);
      tick();
      a_single(1, 19'h00300, 16'h5555, 1'b0, 2'b11, 16'hCAFE, 1, cnt);
      chk("io_qacc_cycles", 64'(cnt), 64'd1);
      a_io[0] = 1'b0; a_access[0] = 1'b0; a_addr[0] = '0;
      tick();

      // Round-robin, all four ports requesting continuously.
      for (int p = 0; p < NP; p++) b_addr[p] = 19'h00400 + 19'(p);
      b_access = 4'hF;
      for (int g = 0; g < 5; g++) begin
         int ep;
         ep = g % NP;
         exp_b.push_back('{ep, 16'hD000 + 16'(g)});
         @(negedge clk);
         chk("rr_gidx",  64'(b_gidx),  64'(ep));
         chk("rr_qacc",  64'(b_qacc),  64'd1);
         chk("rr_busy",  64'(b_busy),  64'd0);
         chk("rr_qaddr", 64'(b_qaddr), 64'h400 + 64'(ep));
         tick();
         b_qack = 1'b1; b_qdin = 16'hD000 + 16'(g);
         @(negedge clk);
         chk("rr_ack_qacc", 64'(b_qacc), 64'd0);
         chk("rr_ack_busy", 64'(b_busy), 64'd1);
         tick();
         b_qack = 1'b0; b_qdin = '0;
      end

      // Pointer now at 1: with ports 0 and 1 requesting, port 1 wins.
      b_access = 4'b0011;
      @(negedge clk);
      chk("rr_ptr1_gidx", 64'(b_gidx), 64'd1);
      chk("rr_ptr1_qacc", 64'(b_qacc), 64'd1);
      tick();
      // Reset while busy on port 1.
      #3;
      reset_n = 1'b0;
      #1;
      chk("rst_mid_busy", 64'(b_busy), 64'd0);
      chk("rst_mid_qacc", 64'(b_qacc), 64'd0);
      chk("rst_mid_ack",  64'(b_ack),  64'd0);
      @(negedge clk);
      #1;
      reset_n = 1'b1;
      #1;
      chk("post_rst_gidx", 64'(b_gidx), 64'd0);
      chk("post_rst_qacc", 64'(b_qacc), 64'd1);
      exp_b.push_back('{0, 16'h7777});
      tick();
      b_qack = 1'b1; b_qdin = 16'h7777;
      @(negedge clk);
      tick();
      b_qack = 1'b0; b_qdin = '0; b_access = '0;

      repeat (3) tick();
      chk("a_queue_empty", 64'(exp_a.size()), 64'd0);
      chk("b_queue_empty", 64'(exp_b.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
